trap_ctrl: RTL and testbench

- Initiator side of the CSR file's trap/xret update interface.
- Accepts exception and MRET requests from the exec stage, holds the front end flushed until older instructions have drained, and issues a single-cycle trap or xret update to the CSR file.
- Then hands fetch the redirect PC (mtvec base or mepc) over a valid/ready handshake.
- Single-hart, M-mode-only core; exceptions only (no interrupts).

---
 rtl/trap_ctrl.sv | 132 +++++++++++++
 tb/tb_trap_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Trap/xret initiator: takes exception or MRET requests from exec, drains the pipe,
// strobes a one-cycle CSR update, then offers the redirect PC to fetch.
module trap_ctrl #(
  parameter int XLEN = 64,
  parameter int ALEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic [ALEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_valid,
  input  logic            pipeline_empty,
  input  logic [1:0]      privilege_mode,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            busy,
  output logic            flush,
  output logic            trap_do_update,
  output logic [3:0]      trap_mcause,
  output logic [ALEN-1:0] trap_mepc,
  output logic [XLEN-1:0] trap_mtval,
  output logic            xret_do_update,
  output logic [XLEN-1:0] xret_new_mstatus,
  output logic [1:0]      xret_new_privilege_mode,
  output logic            redirect_valid,
  output logic [ALEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic [1:0]      state_dbg
);

  // Handshake: redirect_valid rises in REDIRECT and stays high with redirect_pc
  // unchanged until a cycle where redirect_valid && redirect_ready; IDLE follows.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_UPDATE   = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  localparam logic [1:0] PRIV_M = 2'b11;

  state_t          state_q, state_d;
  logic            kind_xret_q;
  logic [3:0]      cause_q;
  logic [ALEN-1:0] epc_q;
  logic [XLEN-1:0] tval_q;
  logic [ALEN-1:0] rpc_q;
  logic [XLEN-1:0] mst_q;
  logic [1:0]      priv_q;
  logic [XLEN-1:0] mst_after_mret;
  logic [ALEN-1:0] rpc_next;
  logic            unused_bits;

  assign unused_bits = ^{mtvec, mepc};

  always_comb begin
    mst_after_mret        = mstatus;
    mst_after_mret[3]     = mstatus[7];
    mst_after_mret[7]     = 1'b1;
    mst_after_mret[12:11] = PRIV_M;
  end

  // Trap vector is direct mode only; MRET target drops bit 0.
  assign rpc_next = kind_xret_q ? {mepc[ALEN-1:1], 1'b0} : {mtvec[ALEN-1:2], 2'b00};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (exc_valid || mret_valid) state_d = S_DRAIN;
      S_DRAIN:    if (pipeline_empty) state_d = S_UPDATE;
      S_UPDATE:   state_d = S_REDIRECT;
      S_REDIRECT: if (redirect_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      kind_xret_q <= 1'b0;
      cause_q     <= '0;
      epc_q       <= '0;
      tval_q      <= '0;
      rpc_q       <= '0;
      mst_q       <= '0;
      priv_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) begin
        if (exc_valid) begin
          kind_xret_q <= 1'b0;
          cause_q     <= exc_cause;
          epc_q       <= exc_pc;
          tval_q      <= exc_tval;
        end else if (mret_valid) begin
          if (privilege_mode == PRIV_M) begin
            kind_xret_q <= 1'b1;
          end else begin
            // MRET outside M-mode becomes an illegal-instruction trap.
            kind_xret_q <= 1'b0;
            cause_q     <= 4'd2;
            epc_q       <= exc_pc;
            tval_q      <= '0;
          end
        end
      end
      if (state_q == S_UPDATE) begin
        rpc_q  <= rpc_next;
        mst_q  <= mst_after_mret;
        priv_q <= mstatus[12:11];
      end
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign flush          = busy;
  assign trap_do_update = (state_q == S_UPDATE) && !kind_xret_q;
  assign xret_do_update = (state_q == S_UPDATE) && kind_xret_q;
  assign redirect_valid = (state_q == S_REDIRECT);
  assign redirect_pc    = rpc_q;
  assign trap_mcause    = cause_q;
  assign trap_mepc      = epc_q;
  assign trap_mtval     = tval_q;
  // Live value during the strobe, then the captured copy so the payload holds still.
  assign xret_new_mstatus        = (state_q == S_UPDATE) ? mst_after_mret : mst_q;
  assign xret_new_privilege_mode = (state_q == S_UPDATE) ? mstatus[12:11] : priv_q;
  assign state_dbg               = state_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized requests
// checked against a queue of expected CSR updates and redirect targets.
module tb_trap_ctrl;
  localparam int XLEN = 64;
  localparam int ALEN = 64;

  logic            clk, rst;
  logic            exc_valid, mret_valid, pipeline_empty, redirect_ready;
  logic [3:0]      exc_cause;
  logic [ALEN-1:0] exc_pc;
  logic [XLEN-1:0] exc_tval, mstatus, mtvec, mepc;
  logic [1:0]      privilege_mode;
  logic            busy, flush, trap_do_update, xret_do_update, redirect_valid;
  logic [3:0]      trap_mcause;
  logic [ALEN-1:0] trap_mepc, redirect_pc;
  logic [XLEN-1:0] trap_mtval, xret_new_mstatus;
  logic [1:0]      xret_new_privilege_mode, state_dbg;

  trap_ctrl #(.XLEN(XLEN), .ALEN(ALEN)) dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_valid(mret_valid), .pipeline_empty(pipeline_empty),
    .privilege_mode(privilege_mode), .mstatus(mstatus), .mtvec(mtvec), .mepc(mepc),
    .busy(busy), .flush(flush),
    .trap_do_update(trap_do_update), .trap_mcause(trap_mcause),
    .trap_mepc(trap_mepc), .trap_mtval(trap_mtval),
    .xret_do_update(xret_do_update), .xret_new_mstatus(xret_new_mstatus),
    .xret_new_privilege_mode(xret_new_privilege_mode),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic            is_trap;
    logic [3:0]      cause;
    logic [ALEN-1:0] epc;
    logic [XLEN-1:0] tval;
    logic [XLEN-1:0] mst;
    logic [1:0]      priv;
    logic [ALEN-1:0] rpc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic junk();
    exc_valid  = 1'($urandom_range(0, 1));
    mret_valid = 1'($urandom_range(0, 1));
    exc_cause  = 4'($urandom);
    exc_pc     = rnd64();
    exc_tval   = rnd64();
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with it idle again.
  // kind: 0 = exception, 1 = MRET, 2 = both at once.
  task automatic req(input int kind, input logic [1:0] priv, input logic [3:0] cause,
                     input logic [63:0] pc, input logic [63:0] tval, input logic [63:0] mst,
                     input logic [63:0] tvec, input logic [63:0] epc,
                     input int drain, input int rdly);
    exp_t e;
    e = '0;
    exc_valid = (kind != 1); mret_valid = (kind != 0);
    exc_cause = cause; exc_pc = pc; exc_tval = tval;
    privilege_mode = priv; mstatus = mst; mtvec = tvec; mepc = epc;
    pipeline_empty = 1'($urandom_range(0, 1));
    redirect_ready = 1'b0;
    if (kind == 1 && priv == 2'b11) begin
      e.is_trap = 1'b0;
      e.mst = mst;
      e.mst[3] = mst[7];
      e.mst[7] = 1'b1;
      e.mst[12:11] = 2'b11;
      e.priv = mst[12:11];
      e.rpc = epc & ~64'h1;
    end else begin
      e.is_trap = 1'b1;
      e.cause = (kind == 1) ? 4'd2 : cause;
      e.epc = pc;
      e.tval = (kind == 1) ? 64'h0 : tval;
      e.rpc = tvec & ~64'h3;
    end
    exp_q.push_back(e);
    chk("idle_before_req", {62'h0, busy, flush}, 64'h0);

    @(posedge clk); #1;
    chk("drain_entry", {62'h0, busy, flush}, 64'h3);
    junk();
    pipeline_empty = (drain == 0);
    for (int i = 1; i <= drain; i++) begin
      @(posedge clk); #1;
      chk("drain_hold", {61'h0, flush, trap_do_update, xret_do_update}, 64'h4);
      junk();
      if (i == drain) pipeline_empty = 1'b1;
    end

    @(posedge clk); #1;
    chk("update_strobe", {62'h0, flush, trap_do_update | xret_do_update}, 64'h3);
    junk();
    pipeline_empty = 1'($urandom_range(0, 1));

    @(posedge clk); #1;
    chk("redirect_entry", {61'h0, redirect_valid, trap_do_update, xret_do_update}, 64'h4);
    if (rdly == 0) begin
      redirect_ready = 1'b1; exc_valid = 1'b0; mret_valid = 1'b0;
    end else begin
      junk();
    end
    for (int i = 1; i <= rdly; i++) begin
      @(posedge clk); #1;
      chk("backpressure_valid", {62'h0, redirect_valid, flush}, 64'h3);
      if (i == rdly) begin
        redirect_ready = 1'b1; exc_valid = 1'b0; mret_valid = 1'b0;
      end else begin
        junk();
      end
    end

    @(posedge clk); #1;
    chk("idle_after_handshake", {61'h0, busy, flush, redirect_valid}, 64'h0);
    redirect_ready = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    exp_t            cur;
    logic            have_cur, prev_rv, prev_hs;
    logic [ALEN-1:0] prev_pc;
    have_cur = 1'b0; prev_rv = 1'b0; prev_hs = 1'b0; prev_pc = '0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        have_cur = 1'b0; prev_rv = 1'b0; prev_hs = 1'b0;
      end else begin
        if (trap_do_update && xret_do_update)
          chk("both_strobes", 64'h1, 64'h0);
        if (trap_do_update || xret_do_update) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_strobe", {62'h0, trap_do_update, xret_do_update}, 64'h0);
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            chk("strobe_kind", {63'h0, trap_do_update}, {63'h0, cur.is_trap});
            if (cur.is_trap) begin
              chk("trap_mcause", {60'h0, trap_mcause}, {60'h0, cur.cause});
              chk("trap_mepc", trap_mepc, cur.epc);
              chk("trap_mtval", trap_mtval, cur.tval);
            end else begin
              chk("xret_mstatus", xret_new_mstatus, cur.mst);
              chk("xret_priv", {62'h0, xret_new_privilege_mode}, {62'h0, cur.priv});
            end
          end
        end
        if (redirect_valid) begin
          if (prev_rv && !prev_hs) chk("redirect_pc_stable", redirect_pc, prev_pc);
          if (have_cur) begin
            if (cur.is_trap) chk("trap_payload_hold", trap_mepc, cur.epc);
            else chk("xret_payload_hold", xret_new_mstatus, cur.mst);
          end
          if (redirect_ready) begin
            if (!have_cur) chk("redirect_without_update", 64'h1, 64'h0);
            else chk("redirect_pc", redirect_pc, cur.rpc);
            have_cur = 1'b0;
          end
        end else if (prev_rv && !prev_hs) begin
          chk("redirect_valid_dropped", 64'h0, 64'h1);
        end
        prev_rv = redirect_valid;
        prev_hs = redirect_valid && redirect_ready;
        prev_pc = redirect_pc;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    exc_valid = 1'b0; mret_valid = 1'b0; pipeline_empty = 1'b0; redirect_ready = 1'b0;
    exc_cause = '0; exc_pc = '0; exc_tval = '0; privilege_mode = 2'b11;
    mstatus = '0; mtvec = '0; mepc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {59'h0, busy, flush, trap_do_update, xret_do_update, redirect_valid}, 64'h0);
    chk("reset_mcause", {60'h0, trap_mcause}, 64'h0);
    chk("reset_mepc", trap_mepc, 64'h0);
    chk("reset_mtval", trap_mtval, 64'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a drain aborts the exception.
    exc_valid = 1'b1; exc_cause = 4'd5; exc_pc = 64'h3000; exc_tval = 64'h77;
    mtvec = 64'h8000_0000; pipeline_empty = 1'b0;
    @(posedge clk); #1;
    exc_valid = 1'b0;
    chk("abort_drain_busy", {63'h0, busy}, 64'h1);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ctrl", {59'h0, busy, flush, trap_do_update, xret_do_update, redirect_valid}, 64'h0);
    chk("abort_latches", {60'h0, trap_mcause} | trap_mepc | trap_mtval, 64'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    pipeline_empty = 1'b1;
    @(posedge clk); #1;
    chk("abort_stays_idle", {62'h0, busy, redirect_valid}, 64'h0);

    // Basic exception, minimum latency.
    req(0, 2'b11, 4'd2, 64'h1000, 64'hdead_beef, 64'h0, 64'h8000_0103, 64'h0, 0, 0);
    // Drain wait of five cycles.
    req(0, 2'b11, 4'd7, 64'h1234, 64'h55, 64'h0, 64'h8000_0200, 64'h0, 5, 0);
    // Legal MRET.
    req(1, 2'b11, 4'd0, 64'h0, 64'h0, 64'h0000_1880, 64'h8000_0103, 64'h2003, 0, 0);
    // MRET from U-mode becomes an illegal-instruction trap.
    req(1, 2'b00, 4'd9, 64'h40, 64'h1111, 64'h0000_1880, 64'h4000_0001, 64'h2003, 1, 0);
    // Exception and MRET together, with four cycles of backpressure.
    req(2, 2'b11, 4'd11, 64'h5000, 64'habc, 64'h0000_1880, 64'h9000_0002, 64'h6001, 0, 4);
    // Back-to-back request in the first idle cycle.
    req(1, 2'b11, 4'd0, 64'h0, 64'h0, 64'h0000_0800, 64'h0, 64'hffff_ffff_ffff_ffff, 2, 1);

    for (int n = 0; n < 40; n++) begin
      req($urandom_range(0, 2), 2'($urandom), 4'($urandom), rnd64(), rnd64(), rnd64(),
          rnd64(), rnd64(), $urandom_range(0, 4), $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
